// File: rtl/mmio_write_arbiter_pkg.sv
// mmio_arb_pkg: shared types and constants for the MMIO write arbiter.
//   state_t            - arbiter FSM encoding (IDLE, GRANT, HOLD)
//   GPIO_ADDR_DEFAULT  - GPIO output-controller address that needs a settle window
//   HOLD_CNT_WIDTH     - width of the post-write hold counter
//   STATS_WIDTH        - width of the optional grant/stall counters
package mmio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'h1001_0024;
  localparam int unsigned HOLD_CNT_WIDTH    = 8;
  localparam int unsigned STATS_WIDTH       = 16;

endpackage

// File: rtl/mmio_write_arbiter_if.sv
// mmio_write_arbiter_if: requester-side handshake plus the forwarded
// peripheral write port of the MMIO write arbiter.
//   req0/addr0/wdata0, req1/addr1/wdata1 : requester write requests
//   gnt0/gnt1                           : one-cycle grant pulses
//   addr_ram/wdata/enable_sw            : write port into the GPIO controller
//   busy/last_grant                     : arbiter status
// Modports: slave = arbiter view, master = requester/peripheral view.
interface mmio_write_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_WIDTH-1:0] addr_ram;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  enable_sw;
  logic                  busy;
  logic                  last_grant;

  modport slave (
    input  req0, addr0, wdata0, req1, addr1, wdata1,
    output gnt0, gnt1, addr_ram, wdata, enable_sw, busy, last_grant
  );

  modport master (
    output req0, addr0, wdata0, req1, addr1, wdata1,
    input  gnt0, gnt1, addr_ram, wdata, enable_sw, busy, last_grant
  );

endinterface

// File: rtl/mmio_write_arbiter_hold_timer.sv
// mmio_hold_timer: 8-bit post-write hold counter.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val (takes priority over decrement)
//   load_val   : hold length in cycles
//   done       : high while the counter sits at 1 (last hold cycle)
// The counter decrements every cycle while non-zero.
module mmio_hold_timer
  import mmio_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [HOLD_CNT_WIDTH-1:0] load_val,
  output logic                      done
);

  logic [HOLD_CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == HOLD_CNT_WIDTH'(1));

endmodule

// File: rtl/mmio_write_arbiter.sv
// mmio_write_arbiter: round-robin arbiter sharing the GPIO controller write
// port between the CPU store path (req0) and the debug/DMA path (req1).
// After a write to GPIO_ADDR, HOLD_CYCLES idle cycles are enforced so the
// output register and demux settle before the next write.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : mmio_write_arbiter_if.slave (requests, grants, write port,
//                busy, last_grant); all outputs registered
//   grant_cnt0, grant_cnt1, stall_cnt : saturating statistics, present only
//                when MMIO_WRITE_ARBITER_STATS_EN is defined
module mmio_write_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] GPIO_ADDR   = GPIO_ADDR_DEFAULT,
  parameter int unsigned           HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef MMIO_WRITE_ARBITER_STATS_EN
  output logic [STATS_WIDTH-1:0] grant_cnt0,
  output logic [STATS_WIDTH-1:0] grant_cnt1,
  output logic [STATS_WIDTH-1:0] stall_cnt,
`endif
  mmio_write_arbiter_if.slave    bus
);

  state_t                state, state_nxt;
  logic                  gnt0_q, gnt0_nxt;
  logic                  gnt1_q, gnt1_nxt;
  logic                  en_q, en_nxt;
  logic                  busy_q, busy_nxt;
  logic                  lg_q, lg_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic                  winner;
  logic                  hold_load;
  logic                  hold_done;

  mmio_hold_timer u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (HOLD_CNT_WIDTH'(HOLD_CYCLES)),
    .done     (hold_done)
  );

  // Tie goes to the requester that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ~lg_q;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0_nxt  = 1'b0;
    gnt1_nxt  = 1'b0;
    en_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    lg_nxt    = lg_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    hold_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = GRANT;
          gnt0_nxt  = ~winner;
          gnt1_nxt  = winner;
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          lg_nxt    = winner;
          addr_nxt  = winner ? bus.addr1  : bus.addr0;
          wdata_nxt = winner ? bus.wdata1 : bus.wdata0;
        end
      end
      GRANT: begin
        // addr_q holds the address just written during this GRANT cycle.
        if ((addr_q == GPIO_ADDR) && (HOLD_CYCLES != 0)) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_nxt = IDLE;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      lg_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      gnt0_q  <= gnt0_nxt;
      gnt1_q  <= gnt1_nxt;
      en_q    <= en_nxt;
      busy_q  <= busy_nxt;
      lg_q    <= lg_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.enable_sw  = en_q;
  assign bus.busy       = busy_q;
  assign bus.last_grant = lg_q;
  assign bus.addr_ram   = addr_q;
  assign bus.wdata      = wdata_q;

`ifdef MMIO_WRITE_ARBITER_STATS_EN
  // A stall cycle is one where a request is pending and no grant pulse is
  // visible on the outputs during that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (gnt0_nxt && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt1_nxt && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
      if ((bus.req0 || bus.req1) && !(gnt0_q || gnt1_q) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_write_arbiter.sv
module tb_mmio_write_arbiter;

  localparam logic [31:0] GPIO = 32'h1001_0024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mmio_write_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus_a ();
  mmio_write_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus_b ();

`ifdef MMIO_WRITE_ARBITER_STATS_EN
  logic [15:0] gc0_a, gc1_a, st_a, gc0_b, gc1_b, st_b;
`endif

  mmio_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .GPIO_ADDR(GPIO), .HOLD_CYCLES(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
`ifdef MMIO_WRITE_ARBITER_STATS_EN
    .grant_cnt0 (gc0_a),
    .grant_cnt1 (gc1_a),
    .stall_cnt  (st_a),
`endif
    .bus        (bus_a)
  );

  mmio_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .GPIO_ADDR(GPIO), .HOLD_CYCLES(0)) dut_b (
    .clk        (clk),
    .reset      (reset),
`ifdef MMIO_WRITE_ARBITER_STATS_EN
    .grant_cnt0 (gc0_b),
    .grant_cnt1 (gc1_b),
    .stall_cnt  (st_b),
`endif
    .bus        (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.req0 = 0; bus_a.addr0 = '0; bus_a.wdata0 = '0;
    bus_a.req1 = 0; bus_a.addr1 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 0; bus_b.addr0 = '0; bus_b.wdata0 = '0;
    bus_b.req1 = 0; bus_b.addr1 = '0; bus_b.wdata1 = '0;

    // Reset values
    tick();
    check("rst_gnt0", bus_a.gnt0, 0);
    check("rst_gnt1", bus_a.gnt1, 0);
    check("rst_en", bus_a.enable_sw, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_addr", bus_a.addr_ram, 0);
    check("rst_wdata", bus_a.wdata, 0);
    check("rst_lg", bus_a.last_grant, 1);
    reset = 0;

    // GPIO write by requester 0, then requester 1 waits out the hold
    bus_a.req0 = 1; bus_a.addr0 = GPIO; bus_a.wdata0 = 8'hA5;
    tick();
    check("g1_gnt0", bus_a.gnt0, 1);
    check("g1_gnt1", bus_a.gnt1, 0);
    check("g1_en", bus_a.enable_sw, 1);
    check("g1_wdata", bus_a.wdata, 32'hA5);
    check("g1_addr", bus_a.addr_ram, GPIO);
    check("g1_busy", bus_a.busy, 1);
    check("g1_lg", bus_a.last_grant, 0);
    bus_a.req0 = 0;
    bus_a.req1 = 1; bus_a.addr1 = 32'h100; bus_a.wdata1 = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_busy", bus_a.busy, 1);
      check("hold_gnt1", bus_a.gnt1, 0);
      check("hold_en", bus_a.enable_sw, 0);
      check("hold_wdata", bus_a.wdata, 32'hA5);
    end
    tick();
    check("post_hold_busy", bus_a.busy, 0);
    check("post_hold_gnt1", bus_a.gnt1, 0);
    tick();
    check("r1_gnt1", bus_a.gnt1, 1);
    check("r1_en", bus_a.enable_sw, 1);
    check("r1_wdata", bus_a.wdata, 32'h3C);
    check("r1_addr", bus_a.addr_ram, 32'h100);
    check("r1_lg", bus_a.last_grant, 1);
    bus_a.req1 = 0;
    tick();
    check("r1_idle_busy", bus_a.busy, 0);
    check("r1_idle_en", bus_a.enable_sw, 0);
    check("r1_idle_addr", bus_a.addr_ram, 32'h100);

    // Both requesters held high: alternate 0,1,0,1, one write per 2 cycles
    bus_a.req0 = 1; bus_a.addr0 = 32'h200; bus_a.wdata0 = 8'h11;
    bus_a.req1 = 1; bus_a.addr1 = 32'h300; bus_a.wdata1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_gnt0", bus_a.gnt0, (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", bus_a.gnt1, (i % 2 == 1) ? 1 : 0);
      check("rr_wdata", bus_a.wdata, (i % 2 == 0) ? 32'h11 : 32'h22);
      check("rr_en", bus_a.enable_sw, 1);
      tick();
      check("rr_gap_en", bus_a.enable_sw, 0);
      check("rr_gap_busy", bus_a.busy, 0);
    end
    bus_a.req0 = 0; bus_a.req1 = 0;
    tick();
    check("wd_gnt0", bus_a.gnt0, 0);
    check("wd_gnt1", bus_a.gnt1, 0);

    // HOLD_CYCLES=0: GPIO writes never enter HOLD
    bus_b.req0 = 1; bus_b.addr0 = GPIO; bus_b.wdata0 = 8'h77;
    tick();
    check("h0_gnt0", bus_b.gnt0, 1);
    check("h0_busy", bus_b.busy, 1);
    tick();
    check("h0_idle_busy", bus_b.busy, 0);
    tick();
    check("h0_gnt0_again", bus_b.gnt0, 1);
    check("h0_busy_again", bus_b.busy, 1);
    bus_b.req0 = 0;
    tick();
    check("h0_end_busy", bus_b.busy, 0);

    // Reset asserted mid-HOLD (counter at 2)
    bus_a.req0 = 1; bus_a.addr0 = GPIO; bus_a.wdata0 = 8'h5A;
    tick();
    check("mr_gnt0", bus_a.gnt0, 1);
    bus_a.req0 = 0;
    tick(); tick(); tick();
    check("mr_busy_before", bus_a.busy, 1);
    #2 reset = 1;
    #1;
    check("mr_busy", bus_a.busy, 0);
    check("mr_gnt0", bus_a.gnt0, 0);
    check("mr_en", bus_a.enable_sw, 0);
    check("mr_addr", bus_a.addr_ram, 0);
    check("mr_wdata", bus_a.wdata, 0);
    check("mr_lg", bus_a.last_grant, 1);
    bus_a.req0 = 1; bus_a.addr0 = 32'h400; bus_a.wdata0 = 8'h01;
    bus_a.req1 = 1; bus_a.addr1 = 32'h500; bus_a.wdata1 = 8'h02;
    #3 reset = 0;
    tick();
    check("mr_tie_gnt0", bus_a.gnt0, 1);
    check("mr_tie_gnt1", bus_a.gnt1, 0);
    check("mr_tie_wdata", bus_a.wdata, 32'h01);
    bus_a.req0 = 0; bus_a.req1 = 0;
    tick();

`ifdef MMIO_WRITE_ARBITER_STATS_EN
    // 3 grants to req0, 2 to req1; stalls are the 5 pending idle cycles
    reset = 1;
    tick();
    reset = 0;
    bus_a.req0 = 1; bus_a.addr0 = 32'h40; bus_a.wdata0 = 8'h10;
    bus_a.req1 = 1; bus_a.addr1 = 32'h44; bus_a.wdata1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
    end
    bus_a.req1 = 0;
    tick();
    check("st_last_gnt0", bus_a.gnt0, 1);
    bus_a.req0 = 0;
    tick();
    check("st_gc0", gc0_a, 3);
    check("st_gc1", gc1_a, 2);
    check("st_stall", st_a, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
